v810_rf_wb_ctrl: RTL and testbench

//  Write-port controller and load scoreboard for the single-write-port register file.

---
 rtl/v810_rf_wb_ctrl_if.sv | 45 ++++
 rtl/v810_rf_wb_ctrl.sv | 119 +++++++++++
 tb/tb_v810_rf_wb_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v810_rf_wb_ctrl_if.sv
// Register-file write-port bundle: EX writeback, load issue/return,
// hazard check inputs and the resulting register-file write.
interface v810_rf_wb_ctrl_if #(
  parameter int LQ_DEPTH = 2
);
  localparam int CW = $clog2(LQ_DEPTH + 1);

  logic          EX_WE;
  logic [4:0]    EX_WA;
  logic [31:0]   EX_WD;
  logic          LD_ISSUE;
  logic [4:0]    LD_RA;
  logic          LD_ISSUE_RDY;
  logic          LD_RET;
  logic [31:0]   LD_RD;
  logic [4:0]    CHK_RA1;
  logic [4:0]    CHK_RA2;
  logic [4:0]    CHK_WA;
  logic          STALL;
  logic [4:0]    RF_WA;
  logic [31:0]   RF_WD;
  logic          RF_WE;
  logic [CW-1:0] LQ_CNT;
  logic          LD_ERR;

  modport master (
    output EX_WE, EX_WA, EX_WD,
    output LD_ISSUE, LD_RA,
    output LD_RET, LD_RD,
    output CHK_RA1, CHK_RA2, CHK_WA,
    input  LD_ISSUE_RDY, STALL,
    input  RF_WA, RF_WD, RF_WE,
    input  LQ_CNT, LD_ERR
  );

  modport slave (
    input  EX_WE, EX_WA, EX_WD,
    input  LD_ISSUE, LD_RA,
    input  LD_RET, LD_RD,
    input  CHK_RA1, CHK_RA2, CHK_WA,
    output LD_ISSUE_RDY, STALL,
    output RF_WA, RF_WD, RF_WE,
    output LQ_CNT, LD_ERR
  );
endinterface

// File: rtl/v810_rf_wb_ctrl.sv
// Register-file write-port arbiter (EX over load drain) and in-order
// load scoreboard raising STALL on hazards against pending loads.
module v810_rf_wb_ctrl #(
  parameter int LQ_DEPTH = 2
) (
  input logic CLK,
  input logic RESET,
  input logic CE,
  v810_rf_wb_ctrl_if.slave bus
);
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int PW = $clog2(LQ_DEPTH);

  logic [4:0]          tag_q [LQ_DEPTH];
  logic [31:0]         dat_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] dv_q;
  logic [PW-1:0]       hd_q;
  logic [PW-1:0]       tl_q;
  logic [PW-1:0]       rp_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       pend_q;
  logic                err_q;

  logic [LQ_DEPTH-1:0] vld;
  logic                full;
  logic                ex_act;
  logic                drain;
  logic                push;
  logic                pop;
  logic                ret_ok;
  logic                err_set;
  logic                hit;

  assign full   = (cnt_q >= CW'(LQ_DEPTH));
  assign ex_act = bus.EX_WE & (bus.EX_WA != 5'd0);
  assign drain  = !RESET & !ex_act & (cnt_q != '0) & dv_q[hd_q];
  assign push   = CE & bus.LD_ISSUE & !full;
  assign pop    = CE & drain;
  assign ret_ok = CE & bus.LD_RET & (pend_q != '0);
  assign err_set = CE & ((bus.LD_ISSUE & full) |
                         (bus.LD_RET & (pend_q == '0)));

  // Entry i is live when its distance from head is below the count.
  always_comb begin
    vld = '0;
    for (int i = 0; i < LQ_DEPTH; i++)
      vld[i] = CW'(PW'(PW'(i) - hd_q)) < cnt_q;
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (vld[i]) begin
        if (bus.CHK_RA1 != 5'd0 && tag_q[i] == bus.CHK_RA1) hit = 1'b1;
        if (bus.CHK_RA2 != 5'd0 && tag_q[i] == bus.CHK_RA2) hit = 1'b1;
        if (bus.CHK_WA  != 5'd0 && tag_q[i] == bus.CHK_WA)  hit = 1'b1;
      end
    end
  end

  assign bus.STALL        = hit & !RESET;
  assign bus.LD_ISSUE_RDY = RESET | !full;
  assign bus.LQ_CNT       = cnt_q;
  assign bus.LD_ERR       = err_q;

  always_comb begin
    bus.RF_WE = 1'b0;
    bus.RF_WA = 5'd0;
    bus.RF_WD = 32'd0;
    unique case (1'b1)
      ex_act: begin
        bus.RF_WE = 1'b1;
        bus.RF_WA = bus.EX_WA;
        bus.RF_WD = bus.EX_WD;
      end
      drain: begin
        bus.RF_WE = (tag_q[hd_q] != 5'd0);
        bus.RF_WA = tag_q[hd_q];
        bus.RF_WD = dat_q[hd_q];
      end
      default: ;
    endcase
  end

  // Push targets a free slot and returns target a live dv=0 slot,
  // so they never collide with each other or with the popping head.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        tag_q[i] <= 5'd0;
        dat_q[i] <= 32'd0;
      end
      dv_q   <= '0;
      hd_q   <= '0;
      tl_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        tag_q[tl_q] <= bus.LD_RA;
        dv_q[tl_q]  <= 1'b0;
        tl_q        <= tl_q + PW'(1);
      end
      if (ret_ok) begin
        dat_q[rp_q] <= bus.LD_RD;
        dv_q[rp_q]  <= 1'b1;
        rp_q        <= rp_q + PW'(1);
      end
      if (pop)
        hd_q <= hd_q + PW'(1);
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      pend_q <= pend_q + CW'(push) - CW'(ret_ok);
      if (err_set)
        err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_v810_rf_wb_ctrl.sv
// Directed bench for v810_rf_wb_ctrl: expected register-file writes are
// queued by the stimulus and matched by a negedge monitor.
module tb_v810_rf_wb_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  logic CE;

  always #5 CLK = ~CLK;

  v810_rf_wb_ctrl_if #(.LQ_DEPTH(2)) bus ();

  v810_rf_wb_ctrl #(.LQ_DEPTH(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .CE    (CE),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  nchk = 0;
  int  nerr = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic idle();
    bus.EX_WE    = 1'b0;
    bus.EX_WA    = 5'd0;
    bus.EX_WD    = 32'd0;
    bus.LD_ISSUE = 1'b0;
    bus.LD_RA    = 5'd0;
    bus.LD_RET   = 1'b0;
    bus.LD_RD    = 32'd0;
    bus.CHK_RA1  = 5'd0;
    bus.CHK_RA2  = 5'd0;
    bus.CHK_WA   = 5'd0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic expw(logic [4:0] wa, logic [31:0] wd);
    wr_t w;
    w.wa = wa;
    w.wd = wd;
    exp_q.push_back(w);
  endtask

  task automatic issue(logic [4:0] ra);
    cyc();
    bus.LD_ISSUE = 1'b1;
    bus.LD_RA    = ra;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    cyc();
    RESET = 1'b1;
    @(negedge CLK);
    cyc();
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    wr_t w;
    CE    = 1'b1;
    RESET = 1'b1;
    idle();
    fork
      forever begin
        @(negedge CLK);
        if (bus.RF_WE !== 1'b0) begin
          if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_write: got wa=%0d wd=%0h expected none",
                     bus.RF_WA, bus.RF_WD);
          end else begin
            w = exp_q.pop_front();
            chk("rf_wa", 32'(bus.RF_WA), 32'(w.wa));
            chk("rf_wd", bus.RF_WD, w.wd);
          end
        end
      end
    join_none

    @(negedge CLK);
    chk("rst_cnt", 32'(bus.LQ_CNT), 0);
    chk("rst_rdy", 32'(bus.LD_ISSUE_RDY), 1);
    chk("rst_stall", 32'(bus.STALL), 0);
    chk("rst_err", 32'(bus.LD_ERR), 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // load r5 then drain after return
    bus.LD_ISSUE = 1'b1;
    bus.LD_RA    = 5'd5;
    bus.CHK_RA1  = 5'd5;
    @(negedge CLK);
    chk("t1_stall_pre", 32'(bus.STALL), 0);
    cyc();
    bus.CHK_RA1 = 5'd5;
    @(negedge CLK);
    chk("t1_stall", 32'(bus.STALL), 1);
    chk("t1_cnt", 32'(bus.LQ_CNT), 1);
    cyc();
    bus.CHK_RA1 = 5'd5;
    bus.LD_RET  = 1'b1;
    bus.LD_RD   = 32'hDEADBEEF;
    @(negedge CLK);
    chk("t1_stall_ret", 32'(bus.STALL), 1);
    cyc();
    bus.CHK_RA1 = 5'd5;
    expw(5'd5, 32'hDEADBEEF);
    @(negedge CLK);
    chk("t1_stall_drain", 32'(bus.STALL), 1);
    cyc();
    bus.CHK_RA1 = 5'd5;
    @(negedge CLK);
    chk("t1_stall_clr", 32'(bus.STALL), 0);
    chk("t1_cnt_clr", 32'(bus.LQ_CNT), 0);

    // EX holds the port over a ready load for two cycles
    issue(5'd7);
    cyc();
    bus.LD_RET = 1'b1;
    bus.LD_RD  = 32'h77;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      cyc();
      bus.EX_WE   = 1'b1;
      bus.EX_WA   = 5'd3;
      bus.EX_WD   = 32'h33 + 32'(k);
      bus.CHK_RA1 = 5'd7;
      expw(5'd3, 32'h33 + 32'(k));
      @(negedge CLK);
      chk("t2_stall", 32'(bus.STALL), 1);
      chk("t2_cnt", 32'(bus.LQ_CNT), 1);
    end
    cyc();
    expw(5'd7, 32'h77);
    @(negedge CLK);
    cyc();
    @(negedge CLK);
    chk("t2_cnt_clr", 32'(bus.LQ_CNT), 0);

    // full queue, overflow error, duplicate tags
    issue(5'd4);
    issue(5'd4);
    cyc();
    bus.LD_ISSUE = 1'b1;
    bus.LD_RA    = 5'd9;
    @(negedge CLK);
    chk("t3_rdy_full", 32'(bus.LD_ISSUE_RDY), 0);
    chk("t3_cnt_full", 32'(bus.LQ_CNT), 2);
    cyc();
    bus.CHK_WA = 5'd4;
    bus.LD_RET = 1'b1;
    bus.LD_RD  = 32'h41;
    @(negedge CLK);
    chk("t3_err", 32'(bus.LD_ERR), 1);
    chk("t3_cnt_ovf", 32'(bus.LQ_CNT), 2);
    chk("t3_stall0", 32'(bus.STALL), 1);
    cyc();
    bus.CHK_WA = 5'd4;
    bus.LD_RET = 1'b1;
    bus.LD_RD  = 32'h42;
    expw(5'd4, 32'h41);
    @(negedge CLK);
    chk("t3_stall1", 32'(bus.STALL), 1);
    cyc();
    bus.CHK_WA = 5'd4;
    expw(5'd4, 32'h42);
    @(negedge CLK);
    chk("t3_stall2", 32'(bus.STALL), 1);
    cyc();
    bus.CHK_WA = 5'd4;
    @(negedge CLK);
    chk("t3_stall_clr", 32'(bus.STALL), 0);
    chk("t3_cnt_clr", 32'(bus.LQ_CNT), 0);
    do_reset();
    chk("t3_err_clr", 32'(bus.LD_ERR), 0);

    // spurious return, EX to r0, load to r0
    cyc();
    bus.LD_RET = 1'b1;
    bus.LD_RD  = 32'h99;
    @(negedge CLK);
    chk("t4_we_spur", 32'(bus.RF_WE), 0);
    cyc();
    bus.EX_WE = 1'b1;
    bus.EX_WA = 5'd0;
    bus.EX_WD = 32'h55;
    @(negedge CLK);
    chk("t4_err", 32'(bus.LD_ERR), 1);
    chk("t4_we_r0", 32'(bus.RF_WE), 0);
    issue(5'd0);
    cyc();
    bus.LD_RET = 1'b1;
    bus.LD_RD  = 32'hAB;
    @(negedge CLK);
    chk("t4_cnt1", 32'(bus.LQ_CNT), 1);
    cyc();
    @(negedge CLK);
    chk("t4_we_drain", 32'(bus.RF_WE), 0);
    cyc();
    @(negedge CLK);
    chk("t4_cnt0", 32'(bus.LQ_CNT), 0);

    // reset with loads pending
    do_reset();
    issue(5'd1);
    issue(5'd2);
    cyc();
    bus.CHK_RA2 = 5'd2;
    @(negedge CLK);
    chk("t5_stall", 32'(bus.STALL), 1);
    chk("t5_cnt", 32'(bus.LQ_CNT), 2);
    cyc();
    RESET = 1'b1;
    bus.CHK_RA2 = 5'd2;
    bus.LD_RET  = 1'b1;
    bus.LD_RD   = 32'h12;
    @(negedge CLK);
    chk("t5_stall_rst", 32'(bus.STALL), 0);
    chk("t5_rdy_rst", 32'(bus.LD_ISSUE_RDY), 1);
    cyc();
    RESET = 1'b0;
    bus.CHK_RA2 = 5'd2;
    @(negedge CLK);
    chk("t5_cnt_rst", 32'(bus.LQ_CNT), 0);
    chk("t5_stall_post", 32'(bus.STALL), 0);
    chk("t5_err_rst", 32'(bus.LD_ERR), 0);
    cyc();
    bus.LD_RET = 1'b1;
    @(negedge CLK);
    cyc();
    @(negedge CLK);
    chk("t5_err_late", 32'(bus.LD_ERR), 1);

    // clock enable low freezes the queue
    do_reset();
    issue(5'd6);
    cyc();
    CE = 1'b0;
    bus.LD_ISSUE = 1'b1;
    bus.LD_RA    = 5'd8;
    bus.LD_RET   = 1'b1;
    bus.LD_RD    = 32'h11;
    bus.CHK_RA1  = 5'd6;
    @(negedge CLK);
    chk("t6_stall_ce", 32'(bus.STALL), 1);
    cyc();
    CE = 1'b1;
    bus.CHK_RA1 = 5'd8;
    @(negedge CLK);
    chk("t6_cnt", 32'(bus.LQ_CNT), 1);
    chk("t6_stall8", 32'(bus.STALL), 0);
    chk("t6_err", 32'(bus.LD_ERR), 0);
    cyc();
    bus.LD_RET = 1'b1;
    bus.LD_RD  = 32'h66;
    @(negedge CLK);
    cyc();
    expw(5'd6, 32'h66);
    @(negedge CLK);
    cyc();
    @(negedge CLK);
    chk("t6_cnt_clr", 32'(bus.LQ_CNT), 0);

    cyc();
    @(negedge CLK);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
